sweep_scheduler: RTL and testbench

Top-level sequencer for the arbitrage engine. It accepts edge-weight updates from the price feed and writes them into the adjacency matrix. Once the update queue drains, it runs one Bellman-Ford sweep: vertex init, up to NODES-1 relaxation passes, then the negative-cycle detector. It holds each phase engine in reset when that engine is idle, and it owns the adjacency-matrix write port so updates never collide with a running sweep.

---
 rtl/sweep_scheduler.sv | 169 ++++++++++++++++
 tb/tb_sweep_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_scheduler.sv
// Bellman-Ford sweep sequencer: owns the adjacency-matrix write port, applies
// queued edge updates, then drives init / relax / cycle-detect engines through one sweep.
module sweep_scheduler #(
    parameter int NODES        = 16,
    parameter int PRED_WIDTH   = 3,
    parameter int WEIGHT_WIDTH = 15,
    parameter int TIMEOUT      = 4096
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    edge_valid,
    output logic                    edge_ready,
    input  logic [PRED_WIDTH:0]     edge_src,
    input  logic [PRED_WIDTH:0]     edge_dst,
    input  logic [WEIGHT_WIDTH:0]   edge_weight,
    output logic                    adjmat_wen,
    output logic [PRED_WIDTH:0]     adjmat_w_row,
    output logic [PRED_WIDTH:0]     adjmat_w_col,
    output logic [WEIGHT_WIDTH:0]   adjmat_w_data,
    output logic                    init_reset,
    input  logic                    init_done,
    output logic                    relax_reset,
    input  logic                    relax_done,
    input  logic                    relax_changed,
    output logic                    cycle_reset,
    input  logic                    cycle_done,
    output logic                    sweep_busy,
    output logic [PRED_WIDTH:0]     pass_count,
    output logic [15:0]             sweep_count,
    output logic                    timeout_err
);

    // state      | meaning
    // IDLE       | accepting updates; starts a sweep when dirty and no update pending
    // WRITE      | one-cycle adjacency-matrix write of the latched update
    // INIT_WAIT  | vertex-init engine running
    // RELAX_GO   | one-cycle relax_reset pulse to re-arm the relaxation engine
    // RELAX_WAIT | relaxation pass running
    // CYCLE_WAIT | negative-cycle detector running
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WRITE      = 3'd1;
    localparam logic [2:0] S_INIT_WAIT  = 3'd2;
    localparam logic [2:0] S_RELAX_GO   = 3'd3;
    localparam logic [2:0] S_RELAX_WAIT = 3'd4;
    localparam logic [2:0] S_CYCLE_WAIT = 3'd5;

    localparam int PW = PRED_WIDTH + 1;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [PRED_WIDTH:0] LAST_PASS = PW'(NODES - 1);

    logic [2:0]          state;
    logic [2:0]          state_next;
    logic                dirty;
    logic [TW-1:0]       timer;
    logic                timer_end;
    logic [PRED_WIDTH:0] pass_inc;
    logic                accept;
    logic                start_sweep;
    logic                pass_done;
    logic                sweep_done;
    logic                timeout_hit;

    assign timer_end = (timer == TIMER_LAST);
    assign pass_inc  = pass_count + 1'b1;

    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        start_sweep = 1'b0;
        pass_done   = 1'b0;
        sweep_done  = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (edge_valid && edge_ready) begin
                    accept     = 1'b1;
                    state_next = S_WRITE;
                end else if (dirty) begin
                    start_sweep = 1'b1;
                    state_next  = S_INIT_WAIT;
                end
            end
            S_WRITE: state_next = S_IDLE;
            S_INIT_WAIT: begin
                if (init_done) begin
                    state_next = S_RELAX_GO;
                end else if (timer_end) begin
                    timeout_hit = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            S_RELAX_GO: state_next = S_RELAX_WAIT;
            S_RELAX_WAIT: begin
                if (relax_done) begin
                    pass_done  = 1'b1;
                    // stop early once a pass changes nothing, or after NODES-1 passes
                    state_next = (!relax_changed || pass_inc == LAST_PASS) ? S_CYCLE_WAIT
                                                                          : S_RELAX_GO;
                end else if (timer_end) begin
                    timeout_hit = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            S_CYCLE_WAIT: begin
                if (cycle_done) begin
                    sweep_done = 1'b1;
                    state_next = S_IDLE;
                end else if (timer_end) begin
                    timeout_hit = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            dirty         <= 1'b0;
            timer         <= '0;
            edge_ready    <= 1'b0;
            adjmat_wen    <= 1'b0;
            adjmat_w_row  <= '0;
            adjmat_w_col  <= '0;
            adjmat_w_data <= '0;
            init_reset    <= 1'b1;
            relax_reset   <= 1'b1;
            cycle_reset   <= 1'b1;
            sweep_busy    <= 1'b0;
            pass_count    <= '0;
            sweep_count   <= '0;
            timeout_err   <= 1'b0;
        end else begin
            state       <= state_next;
            timer       <= (state_next != state) ? '0 : timer + 1'b1;
            edge_ready  <= (state_next == S_IDLE);
            adjmat_wen  <= (state_next == S_WRITE);
            init_reset  <= (state_next != S_INIT_WAIT);
            relax_reset <= (state_next != S_RELAX_WAIT);
            cycle_reset <= (state_next != S_CYCLE_WAIT);
            sweep_busy  <= (state_next == S_INIT_WAIT)  || (state_next == S_RELAX_GO) ||
                           (state_next == S_RELAX_WAIT) || (state_next == S_CYCLE_WAIT);
            if (accept) begin
                adjmat_w_row  <= edge_src;
                adjmat_w_col  <= edge_dst;
                adjmat_w_data <= edge_weight;
                dirty         <= 1'b1;
            end
            if (start_sweep) begin
                dirty      <= 1'b0;
                pass_count <= '0;
            end
            if (pass_done) begin
                pass_count <= pass_inc;
            end
            if (sweep_done) begin
                sweep_count <= sweep_count + 16'd1;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
                dirty       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sweep_scheduler.sv
// Scoreboard bench for sweep_scheduler: stimulus queues expected writes and sweep
// results, a negedge monitor pops and compares them as the DUT presents them.
module tb_sweep_scheduler;

    localparam int NODES = 16;
    localparam int TMO   = 64;

    typedef struct packed {
        logic [3:0]  row;
        logic [3:0]  col;
        logic [15:0] data;
    } wr_t;

    typedef struct packed {
        logic [3:0]  passes;
        logic [15:0] sc;
    } sw_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        edge_valid;
    logic        edge_ready;
    logic [3:0]  edge_src;
    logic [3:0]  edge_dst;
    logic [15:0] edge_weight;
    logic        adjmat_wen;
    logic [3:0]  adjmat_w_row;
    logic [3:0]  adjmat_w_col;
    logic [15:0] adjmat_w_data;
    logic        init_reset;
    logic        init_done;
    logic        relax_reset;
    logic        relax_done;
    logic        relax_changed;
    logic        cycle_reset;
    logic        cycle_done;
    logic        sweep_busy;
    logic [3:0]  pass_count;
    logic [15:0] sweep_count;
    logic        timeout_err;

    always #5 clk = ~clk;

    sweep_scheduler #(
        .NODES(NODES), .PRED_WIDTH(3), .WEIGHT_WIDTH(15), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .edge_valid(edge_valid), .edge_ready(edge_ready),
        .edge_src(edge_src), .edge_dst(edge_dst), .edge_weight(edge_weight),
        .adjmat_wen(adjmat_wen), .adjmat_w_row(adjmat_w_row),
        .adjmat_w_col(adjmat_w_col), .adjmat_w_data(adjmat_w_data),
        .init_reset(init_reset), .init_done(init_done),
        .relax_reset(relax_reset), .relax_done(relax_done), .relax_changed(relax_changed),
        .cycle_reset(cycle_reset), .cycle_done(cycle_done),
        .sweep_busy(sweep_busy), .pass_count(pass_count),
        .sweep_count(sweep_count), .timeout_err(timeout_err)
    );

    int   total = 0;
    int   bad = 0;
    int   ready_in_busy = 0;
    int   exp_sc = 0;
    logic [15:0] last_sc = 16'd0;
    wr_t  exp_wr[$];
    sw_t  exp_sw[$];
    wr_t  mon_wr;
    sw_t  mon_sw;

    logic [3:0]  b_src [4] = '{4'd0, 4'd6, 4'd15, 4'd9};
    logic [3:0]  b_dst [4] = '{4'd1, 4'd7, 4'd0, 4'd3};
    logic [15:0] b_w   [4] = '{16'd10, 16'hFF00, 16'd32767, 16'h8000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (sweep_busy === 1'b1 && edge_ready === 1'b1) ready_in_busy++;
    endtask

    always @(negedge clk) begin
        if (adjmat_wen === 1'b1) begin
            if (exp_wr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: row=%0d col=%0d data=%0d expected none",
                         adjmat_w_row, adjmat_w_col, adjmat_w_data);
            end else begin
                mon_wr = exp_wr.pop_front();
                check("wr_row", adjmat_w_row, mon_wr.row);
                check("wr_col", adjmat_w_col, mon_wr.col);
                check("wr_data", adjmat_w_data, mon_wr.data);
            end
        end
        if (sweep_count !== last_sc && sweep_count !== 16'd0) begin
            if (exp_sw.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_sweep: sweep_count=%0d expected no change", sweep_count);
            end else begin
                mon_sw = exp_sw.pop_front();
                check("sweep_passes", pass_count, mon_sw.passes);
                check("sweep_count", sweep_count, mon_sw.sc);
            end
        end
        last_sc = sweep_count;
    end

    task automatic send_update(input logic [3:0] s, input logic [3:0] d, input logic [15:0] w);
        int n = 0;
        edge_src    = s;
        edge_dst    = d;
        edge_weight = w;
        edge_valid  = 1'b1;
        while (edge_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("update_ready", edge_ready, 1);
        exp_wr.push_back(wr_t'{s, d, w});
        tick();
        edge_valid = 1'b0;
    endtask

    // Plays all three engines; early = pass number reporting relax_changed=0 (0: never).
    task automatic do_sweep(input int early, input int exp_passes);
        int n = 0;
        int p = 0;
        bit last = 1'b0;
        exp_sc++;
        exp_sw.push_back(sw_t'{exp_passes[3:0], exp_sc[15:0]});
        while (init_reset !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        check("init_start", init_reset, 0);
        tick();
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        check("relax_go_after_init", relax_reset, 1);
        while (!last && p < 20) begin
            n = 0;
            while (relax_reset !== 1'b0 && n < 10) begin
                tick();
                n++;
            end
            if (relax_reset !== 1'b0) begin
                check("relax_start", relax_reset, 0);
                break;
            end
            tick();
            relax_done    = 1'b1;
            relax_changed = (p + 1 != early);
            p++;
            tick();
            relax_done    = 1'b0;
            relax_changed = 1'b0;
            last = (p == early) || (p == NODES - 1);
            if (last) begin
                check("cycle_entry", cycle_reset, 0);
                check("pass_count", pass_count, p);
            end else begin
                check("relax_rearm", relax_reset, 1);
            end
        end
        check("relax_pulses", p, exp_passes);
        tick();
        cycle_done = 1'b1;
        tick();
        cycle_done = 1'b0;
        check("sweep_idle", sweep_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int i;
        int first_init;
        int n;
        int n_low;
        int acc [4];
        reset_n = 1'b0;
        edge_valid = 1'b0;
        edge_src = '0;
        edge_dst = '0;
        edge_weight = '0;
        init_done = 1'b0;
        relax_done = 1'b0;
        relax_changed = 1'b0;
        cycle_done = 1'b0;
        repeat (3) tick();
        check("rst_edge_ready", edge_ready, 0);
        check("rst_wen", adjmat_wen, 0);
        check("rst_init_reset", init_reset, 1);
        check("rst_relax_reset", relax_reset, 1);
        check("rst_cycle_reset", cycle_reset, 1);
        check("rst_busy", sweep_busy, 0);
        check("rst_pass_count", pass_count, 0);
        check("rst_sweep_count", sweep_count, 0);
        check("rst_timeout", timeout_err, 0);
        reset_n = 1'b1;
        tick();
        tick();
        check("post_rst_ready", edge_ready, 1);
        check("post_rst_init_reset", init_reset, 1);

        // single update then a full sweep with every pass changing
        send_update(4'd2, 4'd5, -16'sd300);
        check("t1_wen", adjmat_wen, 1);
        check("t1_ready_low", edge_ready, 0);
        tick();
        check("t1_ready_back", edge_ready, 1);
        check("t1_wen_once", adjmat_wen, 0);
        check("t1_init_still_reset", init_reset, 1);
        tick();
        check("t1_init_fall", init_reset, 0);
        check("t1_busy", sweep_busy, 1);
        check("t1_pass_clear", pass_count, 0);
        do_sweep(0, 15);
        check("t1_sweep_count", sweep_count, 1);

        // early exit on pass 3
        send_update(4'd1, 4'd3, 16'd77);
        do_sweep(3, 3);
        check("t2_sweep_count", sweep_count, 2);

        // four back-to-back updates, one sweep after the last write
        i = 0;
        first_init = -1;
        for (int c = 0; c < 12; c++) begin
            if (i < 4) begin
                edge_valid  = 1'b1;
                edge_src    = b_src[i];
                edge_dst    = b_dst[i];
                edge_weight = b_w[i];
                if (edge_ready === 1'b1) begin
                    exp_wr.push_back(wr_t'{b_src[i], b_dst[i], b_w[i]});
                    acc[i] = c;
                    i++;
                end
            end else begin
                edge_valid = 1'b0;
            end
            if (init_reset === 1'b0 && first_init < 0) first_init = c;
            tick();
        end
        for (int k = 0; k < 4; k++) check("t3_accept_cycle", acc[k], 2 * k);
        check("t3_init_fall_cycle", first_init, 9);
        do_sweep(2, 2);
        repeat (10) tick();
        check("t3_single_sweep_busy", sweep_busy, 0);
        check("t3_single_sweep_init", init_reset, 1);
        check("t3_sweep_count", sweep_count, 3);

        // update held during a sweep is taken afterwards and triggers another sweep
        send_update(4'd7, 4'd8, 16'hFFFF);
        tick();
        tick();
        check("t4_busy", sweep_busy, 1);
        edge_valid  = 1'b1;
        edge_src    = 4'd9;
        edge_dst    = 4'd10;
        edge_weight = 16'd1234;
        exp_wr.push_back(wr_t'{4'd9, 4'd10, 16'd1234});
        ready_in_busy = 0;
        do_sweep(5, 5);
        check("t4_ready_after_sweep", edge_ready, 1);
        check("t4_ready_in_busy", ready_in_busy, 0);
        tick();
        edge_valid = 1'b0;
        check("t4_held_write", adjmat_wen, 1);
        do_sweep(1, 1);
        check("t4_sweep_count", sweep_count, 5);

        // init_done never comes: phase timeout
        send_update(4'd4, 4'd4, 16'd5);
        n = 0;
        n_low = 0;
        while (timeout_err !== 1'b1 && n < 200) begin
            if (init_reset === 1'b0) n_low++;
            tick();
            n++;
        end
        check("t5_timeout_err", timeout_err, 1);
        check("t5_init_low_cycles", n_low, TMO);
        check("t5_init_reset", init_reset, 1);
        check("t5_relax_reset", relax_reset, 1);
        check("t5_cycle_reset", cycle_reset, 1);
        check("t5_busy", sweep_busy, 0);
        check("t5_idle_ready", edge_ready, 1);
        check("t5_sweep_count", sweep_count, 5);
        repeat (5) tick();
        check("t5_no_retry", init_reset, 1);
        check("t5_sticky", timeout_err, 1);

        // reset asserted mid-sweep
        send_update(4'd2, 4'd2, 16'd3);
        tick();
        tick();
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        tick();
        check("t6_in_relax", relax_reset, 0);
        reset_n = 1'b0;
        tick();
        check("t6_relax_reset", relax_reset, 1);
        check("t6_init_reset", init_reset, 1);
        check("t6_cycle_reset", cycle_reset, 1);
        check("t6_timeout_clear", timeout_err, 0);
        check("t6_sweep_count", sweep_count, 0);
        check("t6_ready", edge_ready, 0);
        reset_n = 1'b1;
        tick();
        tick();
        check("t6_ready_after", edge_ready, 1);
        check("t6_no_sweep", sweep_busy, 0);

        repeat (3) tick();
        check("wr_queue_empty", exp_wr.size(), 0);
        check("sweep_queue_empty", exp_sw.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
